// File: rtl/conv_clause_array.sv
// Sliding PATCH x PATCH window over a column-serial pixel stream; evaluates N_CLAUSES
// include/negated-include clauses per patch and OR-reduces them per image.
module conv_clause_array #(
  parameter int PATCH     = 3,
  parameter int IMG_W     = 28,
  parameter int N_STRIPS  = 26,
  parameter int N_CLAUSES = 4,
  parameter int X_W       = 5,
  parameter int Y_W       = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               img_start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PATCH-1:0]                   pixels,
  input  logic [N_CLAUSES*PATCH*PATCH-1:0]   rule,
  input  logic [N_CLAUSES*PATCH*PATCH-1:0]   neg_rule,
  input  logic                               train_mode,
  output logic                               patch_valid,
  output logic [N_CLAUSES-1:0]               patch_clause,
  output logic [X_W-1:0]                     patch_x,
  output logic [Y_W-1:0]                     patch_y,
  output logic                               img_valid,
  input  logic                               img_ready,
  output logic [N_CLAUSES-1:0]               img_clause,
  output logic [1:0]                         dbg_state
);

  localparam int PP = PATCH * PATCH;
  localparam logic [X_W-1:0] FIRST_COL  = X_W'(PATCH - 1);
  localparam logic [X_W-1:0] LAST_COL   = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] LAST_STRIP = Y_W'(N_STRIPS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, SLIDE = 2'd2, DONE = 2'd3} state_t;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // in_valid/in_ready carry column beats; img_valid/img_ready carry the per-image result,
  // and img_valid/img_clause hold steady until that transfer.
  state_t               state;
  logic [PP-1:0]        win;
  logic [X_W-1:0]       col_cnt;
  logic [Y_W-1:0]       strip;
  logic [N_CLAUSES-1:0] acc;

  logic [PP-1:0]        base_win;
  logic [X_W-1:0]       base_col;
  logic [Y_W-1:0]       base_strip;
  logic [N_CLAUSES-1:0] base_acc;
  logic [PP-1:0]        nwin;
  logic [N_CLAUSES-1:0] match;
  logic                 accept;
  logic                 complete;
  logic                 fire;
  logic                 wrap;
  logic                 last;
  logic [X_W-1:0]       nxt_col;
  logic [Y_W-1:0]       nxt_strip;
  logic [N_CLAUSES-1:0] nxt_acc;

  assign in_ready  = !(img_valid && !img_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // img_start zeroes the working state before a same-cycle beat is applied
  assign base_win   = img_start ? '0 : win;
  assign base_col   = img_start ? '0 : col_cnt;
  assign base_strip = img_start ? '0 : strip;
  assign base_acc   = img_start ? '0 : acc;

  // Window bit r*PATCH+k: row r, column k; k=PATCH-1 is the newest column.
  for (genvar r = 0; r < PATCH; r++) begin : g_row
    for (genvar k = 0; k < PATCH; k++) begin : g_col
      if (k == PATCH - 1) begin : g_new
        assign nwin[r*PATCH+k] = pixels[r];
      end else begin : g_shift
        assign nwin[r*PATCH+k] = base_win[r*PATCH+k+1];
      end
    end
  end

  for (genvar c = 0; c < N_CLAUSES; c++) begin : g_clause
    logic [PP-1:0] inc_m;
    logic [PP-1:0] neg_m;
    logic [PP-1:0] lits;
    assign inc_m    = rule[c*PP +: PP];
    assign neg_m    = neg_rule[c*PP +: PP];
    assign lits     = (nwin | ~inc_m) & (~nwin | ~neg_m);
    assign match[c] = (|(inc_m | neg_m)) ? (&lits) : train_mode;
  end

  assign complete  = base_col >= FIRST_COL;
  assign fire      = accept && complete;
  assign wrap      = base_col == LAST_COL;
  assign last      = wrap && (base_strip == LAST_STRIP);
  assign nxt_col   = wrap ? '0 : base_col + 1'b1;
  assign nxt_strip = !wrap ? base_strip : (last ? '0 : base_strip + 1'b1);
  assign nxt_acc   = fire ? (base_acc | match) : base_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      win          <= '0;
      col_cnt      <= '0;
      strip        <= '0;
      acc          <= '0;
      patch_valid  <= 1'b0;
      patch_clause <= '0;
      patch_x      <= '0;
      patch_y      <= '0;
      img_valid    <= 1'b0;
      img_clause   <= '0;
    end else begin
      if (accept) begin
        // A strip wrap empties the window so no patch straddles two strips
        win     <= wrap ? '0 : nwin;
        col_cnt <= nxt_col;
        strip   <= nxt_strip;
        acc     <= last ? '0 : nxt_acc;
      end else if (img_start) begin
        win     <= '0;
        col_cnt <= '0;
        strip   <= '0;
        acc     <= '0;
      end

      patch_valid <= fire;
      if (fire) begin
        patch_clause <= match;
        patch_x      <= base_col - FIRST_COL;
        patch_y      <= base_strip;
      end

      if (accept && last) begin
        img_valid  <= 1'b1;
        img_clause <= nxt_acc;
      end else if (img_valid && img_ready) begin
        img_valid  <= 1'b0;
      end

      if (accept && last) begin
        state <= DONE;
      end else if (img_valid && !img_ready) begin
        state <= DONE;
      end else if (accept) begin
        state <= (nxt_col < FIRST_COL) ? FILL : SLIDE;
      end else if (img_start || state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_conv_clause_array.sv
// Self-checking bench for conv_clause_array: random and directed images against a
// patch-level reference model built from the image array.
module tb_conv_clause_array;

  localparam int P  = 3;
  localparam int W  = 5;
  localparam int S  = 2;
  localparam int NC = 4;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int PP = P * P;
  localparam int EW = XW + YW + NC;

  logic              clk;
  logic              rst;
  logic              img_start;
  logic              in_valid;
  logic              in_ready;
  logic [P-1:0]      pixels;
  logic [NC*PP-1:0]  rule;
  logic [NC*PP-1:0]  neg_rule;
  logic              train_mode;
  logic              patch_valid;
  logic [NC-1:0]     patch_clause;
  logic [XW-1:0]     patch_x;
  logic [YW-1:0]     patch_y;
  logic              img_valid;
  logic              img_ready;
  logic [NC-1:0]     img_clause;
  logic [1:0]        dbg_state;

  conv_clause_array #(
    .PATCH(P), .IMG_W(W), .N_STRIPS(S), .N_CLAUSES(NC), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk(clk), .rst(rst), .img_start(img_start), .in_valid(in_valid), .in_ready(in_ready),
    .pixels(pixels), .rule(rule), .neg_rule(neg_rule), .train_mode(train_mode),
    .patch_valid(patch_valid), .patch_clause(patch_clause), .patch_x(patch_x),
    .patch_y(patch_y), .img_valid(img_valid), .img_ready(img_ready),
    .img_clause(img_clause), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit            img [0:S+P-2][0:W-1];
  logic [EW-1:0] exp_q[$];
  logic [NC-1:0] exp_img;
  logic [NC-1:0] exp_hold;
  logic          exp_iv;
  logic          last_m;
  int            beat_idx;
  int            n_checks;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NC-1:0] ref_clause(input int x, input int y);
    logic [NC-1:0] res;
    logic [PP-1:0] inc;
    logic [PP-1:0] ng;
    bit            p;
    for (int c = 0; c < NC; c++) begin
      inc = rule[c*PP +: PP];
      ng  = neg_rule[c*PP +: PP];
      if ((inc | ng) == '0) begin
        res[c] = train_mode;
      end else begin
        res[c] = 1'b1;
        for (int r = 0; r < P; r++)
          for (int k = 0; k < P; k++) begin
            p = img[y+r][x+k];
            if (inc[r*P+k] && !p) res[c] = 1'b0;
            if (ng[r*P+k] && p)   res[c] = 1'b0;
          end
      end
    end
    return res;
  endfunction

  task automatic build_expect();
    logic [NC-1:0] cl;
    exp_q.delete();
    exp_img = '0;
    for (int y = 0; y < S; y++)
      for (int x = 0; x <= W - P; x++) begin
        cl = ref_clause(x, y);
        exp_q.push_back({XW'(x), YW'(y), cl});
        exp_img |= cl;
      end
  endtask

  function automatic logic [P-1:0] col_px(input int idx);
    logic [P-1:0] px;
    for (int r = 0; r < P; r++) px[r] = img[idx / W + r][idx % W];
    return px;
  endfunction

  task automatic fill_image(input int ones_pct);
    for (int r = 0; r < S + P - 1; r++)
      for (int k = 0; k < W; k++) img[r][k] = ($urandom_range(99) < ones_pct);
  endtask

  task automatic random_rules();
    for (int b = 0; b < NC * PP; b++) begin
      rule[b]     = ($urandom_range(5) == 0);
      neg_rule[b] = !rule[b] && ($urandom_range(5) == 0);
    end
    if ($urandom_range(3) == 0) begin
      rule[2*PP +: PP]     = '0;
      neg_rule[2*PP +: PP] = '0;
    end
    train_mode = 1'($urandom_range(1));
  endtask

  // driver: one clock of stimulus, then check every output against the model
  task automatic step(input logic v, input logic [P-1:0] px, input logic ack, input logic st);
    logic          acc_m;
    logic          hs;
    logic          pulse;
    logic [EW-1:0] e;
    @(negedge clk);
    in_valid  = v;
    pixels    = px;
    img_ready = ack;
    img_start = st;
    #1;
    if (st) beat_idx = 0;
    chk("in_ready", in_ready, !(exp_iv && !ack));
    acc_m  = v && !(exp_iv && !ack);
    hs     = exp_iv && ack;
    pulse  = 1'b0;
    last_m = 1'b0;
    if (acc_m) begin
      pulse = (beat_idx % W) >= P - 1;
      beat_idx++;
      if (beat_idx == W * S) begin
        last_m   = 1'b1;
        beat_idx = 0;
      end
    end
    @(posedge clk);
    #1;
    img_start = 1'b0;
    in_valid  = 1'b0;
    if (last_m) begin
      exp_iv   = 1'b1;
      exp_hold = exp_img;
    end else if (hs) begin
      exp_iv = 1'b0;
    end
    chk("patch_valid", patch_valid, pulse);
    if (patch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("patch_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("patch_xyc", {patch_x, patch_y, patch_clause}, e);
      end
    end
    chk("img_valid", img_valid, exp_iv);
    if (exp_iv) chk("img_clause", img_clause, exp_hold);
  endtask

  task automatic run_image(input int gap_pct, input int ack_pct, input bit rebuild);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    if (rebuild) build_expect();
    while (!done && guard < 400) begin
      guard++;
      step(($urandom_range(99) >= gap_pct), col_px(beat_idx), ($urandom_range(99) < ack_pct), 1'b0);
      done = last_m;
    end
    chk("image_done", done, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    img_start = 1'b1;
    in_valid  = 1'b1;
    pixels    = '1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    img_start = 1'b0;
    in_valid  = 1'b0;
    beat_idx  = 0;
    exp_iv    = 1'b0;
    exp_q.delete();
    chk("rst_patch_valid", patch_valid, 0);
    chk("rst_img_valid", img_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_patch_clause", patch_clause, 0);
    chk("rst_img_clause", img_clause, 0);
    chk("rst_patch_xy", {patch_x, patch_y}, 0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    beat_idx   = 0;
    exp_iv     = 1'b0;
    exp_img    = '0;
    exp_hold   = '0;
    last_m     = 1'b0;
    rst        = 1'b1;
    img_start  = 1'b0;
    in_valid   = 1'b0;
    pixels     = '0;
    rule       = '0;
    neg_rule   = '0;
    train_mode = 1'b0;
    img_ready  = 1'b1;
    do_reset();

    // empty clauses, inference mode then training mode
    fill_image(50);
    run_image(0, 100, 1'b1);
    fill_image(50);
    train_mode = 1'b1;
    run_image(20, 100, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // clause 0 includes only the centre pixel; single lit pixel at row 1, col 3
    train_mode = 1'b0;
    fill_image(0);
    img[1][3] = 1'b1;
    rule[4]   = 1'b1;
    run_image(0, 100, 1'b1);
    chk("centre_img_bit0", img_clause[0], 1);

    // clause 1 fully negated: all-zero image, then one set pixel
    rule = '0;
    neg_rule[PP +: PP] = '1;
    fill_image(0);
    run_image(0, 100, 1'b1);
    fill_image(0);
    img[2][2] = 1'b1;
    run_image(30, 100, 1'b1);

    // img_ready held low: beats ignored, result stable, img_start keeps the held result
    repeat (3) step(1'b1, '1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("ready_after_ack", in_ready, 1);

    // random rule sets and images with random gaps and back-pressure
    for (int i = 0; i < 8; i++) begin
      random_rules();
      fill_image($urandom_range(20, 80));
      run_image($urandom_range(0, 40), $urandom_range(50, 100), 1'b1);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // abort after 7 beats, then a clean image
    random_rules();
    fill_image(50);
    build_expect();
    repeat (7) step(1'b1, col_px(beat_idx), 1'b1, 1'b0);
    build_expect();
    step(1'b0, '0, 1'b1, 1'b1);
    run_image(0, 100, 1'b1);

    // abort with a same-cycle beat taken as column 0 of the new image
    fill_image(50);
    build_expect();
    repeat (9) step(1'b1, col_px(beat_idx), 1'b1, 1'b0);
    fill_image(50);
    build_expect();
    step(1'b1, col_px(0), 1'b1, 1'b1);
    run_image(10, 100, 1'b0);

    // reset mid-strip, then a clean image
    step(1'b0, '0, 1'b1, 1'b0);
    fill_image(50);
    build_expect();
    repeat (7) step(1'b1, col_px(beat_idx), 1'b1, 1'b0);
    do_reset();
    run_image(0, 100, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
